// File: rtl/fadd_seq_if.sv
// fadd_seq_if: start/done handshake plus the shared byte-wide data-memory port of fadd_seq.
// The master side is the sequencer; the slave side is the core and its memory.
interface fadd_seq_if;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    input  start, mem_rd_data,
    output done, busy, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  done, busy, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/fadd_seq.sv
// fadd_seq: fp16 adder sequencer; fetches A/B from data memory, aligns, adds, normalizes, writes back.
// Define FADD_SUB_EN to honour operand signs (effective subtraction); otherwise magnitudes are added.
module fadd_seq #(
  parameter logic [7:0] OP_A_ADDR = 8'd8,
  parameter logic [7:0] OP_B_ADDR = 8'd10,
  parameter logic [7:0] RES_ADDR  = 8'd12
) (
  input logic        clk,
  input logic        reset,
  fadd_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, SWAP, ALIGN, ADD, NORM, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        sign_res;
  logic [5:0]  exp_r;
  logic [10:0] mant_x;
  logic [10:0] mant_y;
  logic [11:0] sum;
  logic [3:0]  align_cnt;
`ifdef FADD_SUB_EN
  logic        eff_sub;
`endif

  logic [4:0]  exp_a;
  logic [4:0]  exp_b;
  logic [4:0]  exp_x;
  logic [4:0]  exp_y;
  logic [4:0]  exp_d;
  logic [10:0] mant_a;
  logic [10:0] mant_b;
  logic        a_is_x;
  logic [3:0]  align_len;
  logic        shift_left;
  logic [15:0] result;

  // Operand ordering: X has the larger exponent, ties broken by mantissa.
  always_comb begin
    exp_a     = op_a[14:10];
    exp_b     = op_b[14:10];
    mant_a    = {|exp_a, op_a[9:0]};
    mant_b    = {|exp_b, op_b[9:0]};
    a_is_x    = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));
    exp_x     = a_is_x ? exp_a : exp_b;
    exp_y     = a_is_x ? exp_b : exp_a;
    exp_d     = exp_x - exp_y;
    align_len = (exp_d > 5'd12) ? 4'd12 : exp_d[3:0];
  end

  always_comb begin
`ifdef FADD_SUB_EN
    shift_left = !sum[10] && (exp_r > 6'd1) && (sum != '0);
`else
    shift_left = 1'b0;
`endif
  end

  always_comb begin
    if (sum == '0) begin
      result = '0;
    end else if (exp_r > 6'd30) begin
      result = {sign_res, 15'h7C00};
    end else begin
      result = {sign_res, exp_r[4:0], sum[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = RD0;
      end
      RD0: begin
        bus.mem_addr = OP_A_ADDR;
        state_nxt    = RD1;
      end
      RD1: begin
        bus.mem_addr = OP_A_ADDR + 8'd1;
        state_nxt    = RD2;
      end
      RD2: begin
        bus.mem_addr = OP_B_ADDR;
        state_nxt    = RD3;
      end
      RD3: begin
        bus.mem_addr = OP_B_ADDR + 8'd1;
        state_nxt    = SWAP;
      end
      SWAP:  state_nxt = (exp_d == '0) ? ADD : ALIGN;
      ALIGN: if (align_cnt == 4'd1) state_nxt = ADD;
      ADD:   state_nxt = NORM;
      // The cycle that finds nothing left to shift is still a NORM cycle.
      NORM:  if (sum[11] || !shift_left) state_nxt = WR_LO;
      WR_LO: begin
        bus.mem_addr    = RES_ADDR;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = result[7:0];
        state_nxt       = WR_HI;
      end
      WR_HI: begin
        bus.mem_addr    = RES_ADDR + 8'd1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = result[15:8];
        state_nxt       = DONE;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        if (bus.start) state_nxt = RD0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_a      <= '0;
      op_b      <= '0;
      sign_res  <= 1'b0;
      exp_r     <= '0;
      mant_x    <= '0;
      mant_y    <= '0;
      sum       <= '0;
      align_cnt <= '0;
`ifdef FADD_SUB_EN
      eff_sub   <= 1'b0;
`endif
    end else begin
      case (state)
        RD0: op_a[7:0]  <= bus.mem_rd_data;
        RD1: op_a[15:8] <= bus.mem_rd_data;
        RD2: op_b[7:0]  <= bus.mem_rd_data;
        RD3: op_b[15:8] <= bus.mem_rd_data;
        SWAP: begin
          exp_r     <= {1'b0, exp_x};
          mant_x    <= a_is_x ? mant_a : mant_b;
          mant_y    <= a_is_x ? mant_b : mant_a;
          align_cnt <= align_len;
`ifdef FADD_SUB_EN
          sign_res  <= a_is_x ? op_a[15] : op_b[15];
          eff_sub   <= op_a[15] ^ op_b[15];
`else
          sign_res  <= op_a[15];
`endif
        end
        ALIGN: begin
          mant_y    <= mant_y >> 1;
          align_cnt <= align_cnt - 4'd1;
        end
        ADD: begin
`ifdef FADD_SUB_EN
          sum <= eff_sub ? ({1'b0, mant_x} - {1'b0, mant_y})
                         : ({1'b0, mant_x} + {1'b0, mant_y});
`else
          sum <= {1'b0, mant_x} + {1'b0, mant_y};
`endif
        end
        NORM: begin
          if (sum[11]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + 6'd1;
          end else if (shift_left) begin
            sum   <= sum << 1;
            exp_r <= exp_r - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_seq.sv
// tb_fadd_seq: self-checking bench for fadd_seq with a byte memory model and a result/latency scoreboard.
// Expectations follow the FADD_SUB_EN setting of the build.
module tb_fadd_seq;

  typedef struct packed {
    logic [15:0] res;
    logic [31:0] lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  res_mem [2];
  logic        clr_res;
  int          checks;
  int          errors;
  exp_t        sb [$];

  fadd_seq_if bus ();

  fadd_seq #(
    .OP_A_ADDR(8'd8),
    .OP_B_ADDR(8'd10),
    .RES_ADDR (8'd12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.mem_addr)
      8'd8:    bus.mem_rd_data = op_a[7:0];
      8'd9:    bus.mem_rd_data = op_a[15:8];
      8'd10:   bus.mem_rd_data = op_b[7:0];
      8'd11:   bus.mem_rd_data = op_b[15:8];
      8'd12:   bus.mem_rd_data = res_mem[0];
      8'd13:   bus.mem_rd_data = res_mem[1];
      default: bus.mem_rd_data = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (clr_res) begin
      res_mem[0] <= 8'hEE;
      res_mem[1] <= 8'hEE;
    end else if (bus.mem_wr_en) begin
      if (bus.mem_addr == 8'd12) res_mem[0] <= bus.mem_wr_data;
      if (bus.mem_addr == 8'd13) res_mem[1] <= bus.mem_wr_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_result;
    clr_res = 1'b1;
    @(posedge clk); #1;
    clr_res = 1'b0;
  endtask

  // One operation: preload operands, pulse start, count edges until done.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] want, input int lat, input int pulse_at);
    int   n;
    logic seen;
    exp_t e;
    op_a = a;
    op_b = b;
    clear_result();
    sb.push_back('{res: want, lat: lat});
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (pulse_at > 0 && n == pulse_at) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
      if (bus.done) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles, want %0d", nm, n, e.lat);
    end else begin
      checks++;
      if (n !== int'(e.lat)) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat);
      end
      checks++;
      if ({res_mem[1], res_mem[0]} !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h want %h", nm, {res_mem[1], res_mem[0]}, e.res);
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    bus.start = 1'b0;
    clr_res   = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_wr_en); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.mem_addr); end
    checks++; if (bus.mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.mem_wr_data); end
    // start together with reset low must not launch an operation
    bus.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_wins: busy got %b want 0", bus.busy); end
    bus.start = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_add;
    run_op("add_equal",   16'h1A04, 16'h1A04, 16'h1E04, 9,  0);
    run_op("add_d2",      16'h4A10, 16'h4204, 16'h4B91, 11, 0);
    run_op("add_d10",     16'h1A04, 16'h4204, 16'h4205, 19, 0);
    run_op("add_d10_swap",16'h4204, 16'h1A04, 16'h4205, 19, 0);
  endtask

  task automatic test_signs;
`ifdef FADD_SUB_EN
    run_op("sub_norm",     16'h4600, 16'hC200, 16'h4200, 11, 0);
    run_op("sub_norm_swap",16'hC200, 16'h4600, 16'h4200, 11, 0);
    run_op("sub_zero",     16'h4204, 16'hC204, 16'h0000, 9,  0);
`else
    run_op("mag_add",      16'h4600, 16'hC200, 16'h4880, 10, 0);
    run_op("mag_add_signa",16'hC200, 16'h4600, 16'hC880, 10, 0);
    run_op("mag_add_eq",   16'h4204, 16'hC204, 16'h4604, 9,  0);
`endif
  endtask

  task automatic test_overflow;
    run_op("ovf_pos", 16'h7A00, 16'h7A00, 16'h7C00, 9, 0);
    run_op("ovf_neg", 16'hFA00, 16'hFA00, 16'hFC00, 9, 0);
  endtask

  task automatic test_reset_mid_align;
    op_a = 16'h1A04;
    op_b = 16'h4204;
    clear_result();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({res_mem[1], res_mem[0]} !== 16'hEEEE) begin
      errors++;
      $display("FAIL midreset_untouched: got %h want eeee", {res_mem[1], res_mem[0]});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    // start pulse during the busy phase must be ignored
    run_op("after_reset_busy_pulse", 16'h1A04, 16'h4204, 16'h4205, 19, 3);
  endtask

  task automatic test_back_to_back;
    int   n;
    exp_t e;
    op_a = 16'h1A04;
    op_b = 16'h1A04;
    clear_result();
    sb.push_back('{res: 16'h1E04, lat: 9});
    sb.push_back('{res: 16'h1E04, lat: 19});
    bus.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 60 && sb.size() > 0) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        e = sb.pop_front();
        checks++;
        if (n !== int'(e.lat)) begin
          errors++;
          $display("FAIL b2b_done_edge: got %0d want %0d", n, e.lat);
        end
        checks++;
        if ({res_mem[1], res_mem[0]} !== e.res) begin
          errors++;
          $display("FAIL b2b_result: got %h want %h", {res_mem[1], res_mem[0]}, e.res);
        end
      end
      if (n == 10) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart_busy: got %b want 1", bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL b2b_timeout: %0d operations not completed", sb.size());
      sb.delete();
    end
    repeat (25) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_signs();
    test_overflow();
    test_reset_mid_align();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fadd_seq.md
# fadd_seq

Hardware sequencer for fp16 addition that shares the byte-wide data memory with the core. On `start` it fetches two half-precision operands from data memory and aligns them, adding one bit shift per cycle. It then normalizes the sum, writes the 16-bit result back to memory and raises `done`. The memory map is the program-3 layout: operand A at bytes 8/9, operand B at bytes 10/11, result at bytes 12/13, little-endian.

## Interface
- `OP_A_ADDR`, 8, byte address of the A low byte; the high byte is at +1.
- `OP_B_ADDR`, 10, byte address of the B low byte; the high byte is at +1.
- `RES_ADDR`, 12, byte address of the result low byte; the high byte is at +1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  request; sampled only in IDLE or DONE.
- `done`  out  1  level ack; high in DONE until the next accepted `start` or reset.
- `busy`  out  1  high in every state except IDLE and DONE.
- `mem_addr`  out  8  data-memory byte address.
- `mem_rd_data`  in  8  combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en`  out  1  write strobe; memory writes on the rising edge while it is high.
- `mem_wr_data`  out  8  write data.

## Operation
- States: IDLE → RD0 → RD1 → RD2 → RD3 → SWAP → [ALIGN] → ADD → NORM → WR_LO → WR_HI → DONE.
- Reads:
  - RD0 reads A low, RD1 reads A high, RD2 reads B low, RD3 reads B high.
  - `mem_addr` is decoded from the state; each byte is captured at the end of its state.
- Operand decode:
  - Sign is bit 15.
  - The exponent field is kept biased, 5 bits.
  - Mantissa is 11 bits: hidden bit `|exp` concatenated with frac[9:0].
- SWAP:
  - The operand with the larger exponent becomes X; on equal exponents, the larger mantissa becomes X.
  - `d = expX − expY`.
  - If `d == 0`, ALIGN is skipped.
- ALIGN:
  - Shifts mant Y right 1 bit per cycle.
  - Runs `A = min(d,12)` cycles; the shifted-out bits are discarded (truncation, no rounding).
- ADD:
  - Same signs: 12-bit `sum = mX + mY`.
  - Result sign is the sign of X.
- NORM, always at least 1 cycle:
  - If sum[11] is set: shift right 1 and increment the exponent, 1 cycle.
  - Otherwise, while sum[10] is 0 and exp > 1 and sum ≠ 0: shift left 1 and decrement the exponent, 1 cycle each.
  - `K` = total NORM cycles.
- Special results:
  - Sum == 0 → result is 0x0000.
  - Post-normalization exponent > 30 → sign | 0x7C00 (infinity).
  - Exponent field 0 is passed through as-is; no denormal handling beyond the hidden-bit rule.
- Writes:
  - WR_LO writes result[7:0] to `RES_ADDR`.
  - WR_HI writes result[15:8] to `RES_ADDR+1`.
  - `mem_wr_en` is high only in these two states.
- Handshake:
  - `start` in IDLE or DONE clears `done` and enters RD0.
  - `start` while `busy` is ignored and has no effect.

## Timing
- Reset values: `done` 0, `busy` 0, `mem_wr_en` 0, `mem_addr` 0x00, `mem_wr_data` 0x00, state IDLE.
- Latency: `done` is first high `8 + A + K` rising edges after the edge that samples `start`.
- The result bytes are in memory by the time `done` is observed high.
- Reset low at any edge (mid-fetch, mid-ALIGN, or between WR_LO and WR_HI) forces IDLE on that edge:
  - No further writes occur.
  - A partially written result is left as-is.
- `start` high on the same edge as reset low: reset wins.
- `start` held high continuously: one operation per pass through DONE, which lasts 1 cycle before re-entering RD0.

## Configuration
- `FADD_SUB_EN`, defined:
  - Differing signs compute the magnitude difference `mX − mY` in ADD.
  - Result sign is the sign of X.
  - NORM performs the left-shift loop.
  - Equal magnitudes give +0 (0x0000).
- `FADD_SUB_EN`, undefined:
  - Signs are ignored for the arithmetic: magnitudes are always added and the result takes the sign of A.
  - NORM is never more than 1 cycle.

## Test plan
- 0x1A04 + 0x1A04 → mem[12]=0x04, mem[13]=0x1E (0x1E04); `done` 9 cycles after `start` (A=0, K=1).
- 0x4A10 + 0x4204 → 0x4B91; A=2, K=1; `done` at 11 cycles.
- 0x1A04 + 0x4204 (d=10) → 0x4205; swap order gives the same result; `done` at 19 cycles.
- 0x4600 + 0xC200:
  - With `FADD_SUB_EN` → 0x4200 (K=2). 0x4204 + 0xC204 → 0x0000.
  - Without `FADD_SUB_EN` → 0x4880.
- 0x7A00 + 0x7A00 → 0x7C00 (overflow to infinity).
- Reset pulled low during ALIGN of the d=10 case:
  - `busy`/`done` are 0 on the next cycle and mem[12..13] are untouched.
  - A subsequent `start` produces the correct 0x4205.
  - `start` pulsed while `busy` is ignored.
